sargantana_itag_ctrl: RTL

// - Initiator side of the I-cache tag array: drives sargantana_itag_memory_sram req/we/vbit/flush/addr/data,

---
 rtl/sargantana_itag_ctrl_pkg.sv | 18 +
 rtl/sargantana_itag_ctrl_if.sv | 21 ++
 rtl/sargantana_itag_victim_sel.sv | 14 +
 rtl/sargantana_itag_ctrl.sv | 87 ++++++++
 4 files changed

// File: rtl/sargantana_itag_ctrl_pkg.sv
// sargantana_icache_pkg: shared I-cache tag controller types, sizes and helpers.
package sargantana_icache_pkg;
    localparam int ICACHE_N_WAY = 4;
    localparam int TAG_DEPTH = 64;
    localparam int TAG_ADDR_WIDHT = $clog2(TAG_DEPTH);
    localparam int TAG_WIDHT = 20;
    localparam int WAY_IDX_W = $clog2(ICACHE_N_WAY);

    typedef enum logic [2:0] {IDLE, COMPARE, MISS, WRITE, FLUSH} itag_state_t;
    typedef logic [ICACHE_N_WAY-1:0] way_oh_t;
    typedef logic [WAY_IDX_W-1:0] way_idx_t;
    typedef logic [TAG_WIDHT-1:0] tag_t;
    typedef logic [TAG_ADDR_WIDHT-1:0] tag_addr_t;

    function automatic way_oh_t lowest_set(way_oh_t v);
        return v & (~v + way_oh_t'(1));
    endfunction
endpackage

// File: rtl/sargantana_itag_ctrl_if.sv
// sargantana_itag_ctrl_if: bus between the tag controller (master) and the tag SRAM (slave).
interface sargantana_itag_ctrl_if;
    import sargantana_icache_pkg::*;
    way_oh_t tag_req_o;
    logic tag_we_o;
    logic tag_vbit_o;
    logic tag_flush_o;
    tag_t tag_data_o;
    tag_addr_t tag_addr_o;
    logic [ICACHE_N_WAY-1:0][TAG_WIDHT-1:0] tag_way_i;
    way_oh_t tag_vbit_i;

    modport master (
        output tag_req_o, tag_we_o, tag_vbit_o, tag_flush_o, tag_data_o, tag_addr_o,
        input  tag_way_i, tag_vbit_i
    );
    modport slave (
        input  tag_req_o, tag_we_o, tag_vbit_o, tag_flush_o, tag_data_o, tag_addr_o,
        output tag_way_i, tag_vbit_i
    );
endinterface

// File: rtl/sargantana_itag_victim_sel.sv
// sargantana_itag_victim_sel: first invalid way, else the round-robin way.
module sargantana_itag_victim_sel
    import sargantana_icache_pkg::*;
(
    input  way_oh_t  vbit_i,
    input  way_idx_t ptr_i,
    output way_oh_t  victim_o,
    output logic     used_rr_o
);
    always_comb begin
        used_rr_o = &vbit_i;
        victim_o = used_rr_o ? way_oh_t'(1) << ptr_i : lowest_set(~vbit_i);
    end
endmodule

// File: rtl/sargantana_itag_ctrl.sv
// sargantana_itag_ctrl: I-cache tag lookup, victim selection, refill tag write and flush.
module sargantana_itag_ctrl
    import sargantana_icache_pkg::*;
(
    input  logic      clk_i,
    input  logic      rstn_i,
    input  logic      lookup_valid_i,
    output logic      lookup_ready_o,
    input  tag_addr_t lookup_idx_i,
    input  tag_t      lookup_tag_i,
    output logic      resp_valid_o,
    output logic      resp_hit_o,
    output way_oh_t   resp_way_o,
    input  logic      refill_valid_i,
    output logic      refill_done_o,
    input  logic      flush_i,
    sargantana_itag_ctrl_if.master tag_mem
);
    itag_state_t state_q, state_d;
    tag_addr_t idx_q, idx_d;
    tag_t tag_q, tag_d;
    way_oh_t victim_q, victim_d;
    logic rr_q, rr_d;
    way_idx_t ptr_q, ptr_d;
    way_oh_t hit_vec, victim;
    logic used_rr, accept, write;

    sargantana_itag_victim_sel u_victim (
        .vbit_i   (tag_mem.tag_vbit_i),
        .ptr_i    (ptr_q),
        .victim_o (victim),
        .used_rr_o(used_rr)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            tag_q    <= '0;
            victim_q <= '0;
            rr_q     <= 1'b0;
            ptr_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            tag_q    <= tag_d;
            victim_q <= victim_d;
            rr_q     <= rr_d;
            ptr_q    <= ptr_d;
        end
    end

    always_comb begin
        hit_vec = '0;
        for (int w = 0; w < ICACHE_N_WAY; w++)
            hit_vec[w] = tag_mem.tag_vbit_i[w] & (tag_mem.tag_way_i[w] == tag_q);
        case (state_q)
            IDLE:    state_d = lookup_valid_i ? COMPARE : IDLE;
            COMPARE: state_d = |hit_vec ? IDLE : MISS;
            MISS:    state_d = refill_valid_i ? WRITE : MISS;
            default: state_d = IDLE;
        endcase
        if (flush_i) state_d = FLUSH;
        idx_d    = accept ? lookup_idx_i : idx_q;
        tag_d    = accept ? lookup_tag_i : tag_q;
        victim_d = state_q == COMPARE ? victim : victim_q;
        rr_d     = state_q == COMPARE ? used_rr : rr_q;
        // Pointer only advances when the round-robin way was actually consumed
        ptr_d    = state_q == FLUSH ? '0 : (write & rr_q) ? ptr_q + way_idx_t'(1) : ptr_q;
    end

    always_comb begin
        lookup_ready_o      = state_q == IDLE & !flush_i;
        accept              = lookup_valid_i & lookup_ready_o;
        write               = state_q == WRITE & !flush_i;
        resp_valid_o        = state_q == COMPARE & !flush_i;
        resp_hit_o          = resp_valid_o & |hit_vec;
        resp_way_o          = !resp_valid_o ? '0 : |hit_vec ? lowest_set(hit_vec) : victim;
        refill_done_o       = write;
        tag_mem.tag_req_o   = accept ? '1 : write ? victim_q : '0;
        tag_mem.tag_we_o    = write;
        tag_mem.tag_vbit_o  = write;
        tag_mem.tag_flush_o = state_q == FLUSH;
        tag_mem.tag_data_o  = write ? tag_q : '0;
        tag_mem.tag_addr_o  = accept ? lookup_idx_i : write ? idx_q : '0;
    end
endmodule
